// File: rtl/pick_drop_sequencer.sv
// Pick-and-place mission sequencer: drives the electromagnet state and move requests, all outputs registered.
// Defining MOVE_TIMEOUT_EN adds a move-state timeout that aborts the job and raises sticky o_timeout_err.
module pick_drop_sequencer #(
   parameter int SETTLE_CYC  = 50000,
   parameter int RELEASE_CYC = 25000,
   parameter int CNT_W       = 20,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_at_pick,
   input  logic       i_at_drop,
   output logic       o_em_state,
   output logic [1:0] o_move_req,
   output logic       o_busy,
   output logic       o_pick_done,
   output logic       o_drop_done,
   output logic       o_abort_done
`ifdef MOVE_TIMEOUT_EN
   ,
   output logic       o_timeout_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GO_PICK,
      S_GRAB,
      S_GO_DROP,
      S_RELEASE
   } state_t;

   localparam logic [1:0]       MV_HOLD    = 2'b00;
   localparam logic [1:0]       MV_PICK    = 2'b01;
   localparam logic [1:0]       MV_DROP    = 2'b10;
   localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LD     = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_aborted, w_aborted_nxt;
   logic             r_em_state, w_em_nxt;
   logic [1:0]       r_move_req, w_move_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_pick_done, w_pick_nxt;
   logic             r_drop_done, w_drop_nxt;
   logic             r_abort_done, w_abort_done_nxt;
   logic             w_move_tmo;

   // The dwell counter doubles as the move timer while in GO_PICK / GO_DROP.
`ifdef MOVE_TIMEOUT_EN
   logic r_timeout_err, w_tmo_err_nxt;
   assign w_move_tmo = (r_cnt == '0);
`else
   assign w_move_tmo = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_aborted     <= 1'b0;
         r_em_state    <= 1'b1;
         r_move_req    <= MV_HOLD;
         r_busy        <= 1'b0;
         r_pick_done   <= 1'b0;
         r_drop_done   <= 1'b0;
         r_abort_done  <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_aborted     <= w_aborted_nxt;
         r_em_state    <= w_em_nxt;
         r_move_req    <= w_move_nxt;
         r_busy        <= w_busy_nxt;
         r_pick_done   <= w_pick_nxt;
         r_drop_done   <= w_drop_nxt;
         r_abort_done  <= w_abort_done_nxt;
`ifdef MOVE_TIMEOUT_EN
         r_timeout_err <= w_tmo_err_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_aborted_nxt    = r_aborted;
      w_em_nxt         = r_em_state;
      w_move_nxt       = r_move_req;
      w_busy_nxt       = r_busy;
      w_pick_nxt       = 1'b0;
      w_drop_nxt       = 1'b0;
      w_abort_done_nxt = 1'b0;
`ifdef MOVE_TIMEOUT_EN
      w_tmo_err_nxt    = r_timeout_err;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_state_nxt = S_GO_PICK;
               w_move_nxt  = MV_PICK;
               w_busy_nxt  = 1'b1;
               w_cnt_nxt   = TMO_LD;
`ifdef MOVE_TIMEOUT_EN
               w_tmo_err_nxt = 1'b0;
`endif
            end
         end
         S_GO_PICK: begin
            // Nothing has been picked yet, so a cancel goes straight home.
            if (i_abort || (!i_at_pick && w_move_tmo)) begin
               w_state_nxt      = S_IDLE;
               w_move_nxt       = MV_HOLD;
               w_busy_nxt       = 1'b0;
               w_abort_done_nxt = 1'b1;
`ifdef MOVE_TIMEOUT_EN
               if (!i_abort) w_tmo_err_nxt = 1'b1;
`endif
            end else if (i_at_pick) begin
               w_state_nxt = S_GRAB;
               w_em_nxt    = 1'b0;
               w_move_nxt  = MV_HOLD;
               w_cnt_nxt   = SETTLE_LD;
            end
`ifdef MOVE_TIMEOUT_EN
            else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
`endif
         end
         S_GRAB: begin
            if (i_abort) begin
               w_state_nxt   = S_RELEASE;
               w_em_nxt      = 1'b1;
               w_move_nxt    = MV_HOLD;
               w_cnt_nxt     = RELEASE_LD;
               w_aborted_nxt = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_GO_DROP;
               w_move_nxt  = MV_DROP;
               w_pick_nxt  = 1'b1;
               w_cnt_nxt   = TMO_LD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         S_GO_DROP: begin
            if (i_abort || (!i_at_drop && w_move_tmo)) begin
               w_state_nxt   = S_RELEASE;
               w_em_nxt      = 1'b1;
               w_move_nxt    = MV_HOLD;
               w_cnt_nxt     = RELEASE_LD;
               w_aborted_nxt = 1'b1;
`ifdef MOVE_TIMEOUT_EN
               if (!i_abort) w_tmo_err_nxt = 1'b1;
`endif
            end else if (i_at_drop) begin
               w_state_nxt = S_RELEASE;
               w_em_nxt    = 1'b1;
               w_move_nxt  = MV_HOLD;
               w_cnt_nxt   = RELEASE_LD;
            end
`ifdef MOVE_TIMEOUT_EN
            else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
`endif
         end
         S_RELEASE: begin
            // Abort is deliberately ignored here: the release dwell always completes.
            if (r_cnt == '0) begin
               w_state_nxt      = S_IDLE;
               w_busy_nxt       = 1'b0;
               w_drop_nxt       = !r_aborted;
               w_abort_done_nxt = r_aborted;
               w_aborted_nxt    = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_em_nxt    = 1'b1;
            w_move_nxt  = MV_HOLD;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign o_em_state    = r_em_state;
   assign o_move_req    = r_move_req;
   assign o_busy        = r_busy;
   assign o_pick_done   = r_pick_done;
   assign o_drop_done   = r_drop_done;
   assign o_abort_done  = r_abort_done;
`ifdef MOVE_TIMEOUT_EN
   assign o_timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_pick_drop_sequencer.sv
// Bench for pick_drop_sequencer: randomized jobs with abort points, expected event edges derived from job timing.
module tb_pick_drop_sequencer;
   localparam int S  = 4;
   localparam int R  = 3;
   localparam int TO = 10;
   localparam int NE = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       at_pick = 1'b0;
   logic       at_drop = 1'b0;
   logic       em_state;
   logic [1:0] move_req;
   logic       busy, pick_done, drop_done, abort_done;
`ifdef MOVE_TIMEOUT_EN
   logic       timeout_err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic       tr_em   [0:NE-1];
   logic [1:0] tr_mv   [0:NE-1];
   logic       tr_busy [0:NE-1];
   logic       tr_pick [0:NE-1];
   logic       tr_drop [0:NE-1];
   logic       tr_abt  [0:NE-1];

   always #5 clk = ~clk;

   pick_drop_sequencer #(
      .SETTLE_CYC(S), .RELEASE_CYC(R), .CNT_W(8), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_at_pick(at_pick), .i_at_drop(at_drop),
      .o_em_state(em_state), .o_move_req(move_req), .o_busy(busy),
      .o_pick_done(pick_done), .o_drop_done(drop_done), .o_abort_done(abort_done)
`ifdef MOVE_TIMEOUT_EN
      , .o_timeout_err(timeout_err)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (em_state !== 1'b1) begin n_errors++; $display("FAIL reset_em: got %b want 1", em_state); end
      n_checks++;
      if (move_req !== 2'b00) begin n_errors++; $display("FAIL reset_move: got %b want 00", move_req); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if ({pick_done, drop_done, abort_done} !== 3'b000)
         begin n_errors++; $display("FAIL reset_pulses: got %b want 000", {pick_done, drop_done, abort_done}); end
`ifdef MOVE_TIMEOUT_EN
      n_checks++;
      if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (move_req !== 2'b01) begin n_errors++; $display("FAIL start_move: got %b want 01", move_req); end
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL start_busy: got %b want 1", busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if ({abort_done, busy, em_state, move_req} !== 5'b10100)
         begin n_errors++; $display("FAIL gopick_abort: got {abt,busy,em,mv}=%b want 10100", {abort_done, busy, em_state, move_req}); end
      tick();
      n_checks++;
      if (abort_done !== 1'b0) begin n_errors++; $display("FAIL abort_pulse_width: got %b want 0", abort_done); end
   endtask

   task automatic test_start_abort();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if ({busy, move_req} !== 3'b000)
         begin n_errors++; $display("FAIL start_abort_same: got {busy,mv}=%b want 000", {busy, move_req}); end
      tick(); tick();
      n_checks++;
      if ({busy, abort_done, em_state} !== 3'b001)
         begin n_errors++; $display("FAIL start_abort_idle: got {busy,abt,em}=%b want 001", {busy, abort_done, em_state}); end
   endtask

   // mode: 0 normal, 1 abort in GO_PICK, 2 abort in GRAB, 3 abort in GO_DROP, 4 abort in RELEASE (ignored)
   task automatic run_job(input int mode);
      int n, d, a, fall;
      int exp_pick, exp_drop, exp_abt, exp_emlo, exp_emhi;
      int f_pick, c_pick, f_drop, c_drop, f_abt, c_abt, f_emlo, f_emhi, f_fall, f_mv10, c_mv11, c_busy_after;
      n = int'($urandom_range(6, 1));
      d = n + S + int'($urandom_range(6, 1));
      case (mode)
         1:       a = int'($urandom_range(n, 1));
         2:       a = n + int'($urandom_range(S, 1));
         3:       a = int'($urandom_range(d, n + S + 1));
         4:       a = d + int'($urandom_range(R, 1));
         default: a = -1;
      endcase
      exp_pick = (mode == 0 || mode == 3 || mode == 4) ? n + S : -1;
      exp_drop = (mode == 0 || mode == 4) ? d + R : -1;
      exp_abt  = (mode == 1) ? a : ((mode == 2 || mode == 3) ? a + R : -1);
      exp_emlo = (mode == 1) ? -1 : n;
      exp_emhi = (mode == 1) ? -1 : ((mode == 2 || mode == 3) ? a : d);
      fall     = (exp_drop >= 0) ? exp_drop : exp_abt;

      for (int e = 0; e < NE; e++) begin
         start   = (e == 0) || (mode == 0 && e == n + 2) ||
                   (e >= 1 && e <= fall && $urandom_range(3, 0) == 0);
         at_pick = (e == n) || ((e == 0 || e > n) && $urandom_range(3, 0) == 0);
         at_drop = (e == d) || ((e < n + S + 1 || e > d) && $urandom_range(3, 0) == 0);
         abort   = (e == a);
         tick();
         tr_em[e]   = em_state;
         tr_mv[e]   = move_req;
         tr_busy[e] = busy;
         tr_pick[e] = pick_done;
         tr_drop[e] = drop_done;
         tr_abt[e]  = abort_done;
      end
      start = 1'b0; at_pick = 1'b0; at_drop = 1'b0; abort = 1'b0;

      f_pick = -1; c_pick = 0; f_drop = -1; c_drop = 0; f_abt = -1; c_abt = 0;
      f_emlo = -1; f_emhi = -1; f_fall = -1; f_mv10 = -1; c_mv11 = 0; c_busy_after = 0;
      for (int e = 0; e < NE; e++) begin
         if (tr_pick[e] === 1'b1) begin if (f_pick < 0) f_pick = e; c_pick++; end
         if (tr_drop[e] === 1'b1) begin if (f_drop < 0) f_drop = e; c_drop++; end
         if (tr_abt[e] === 1'b1)  begin if (f_abt < 0) f_abt = e; c_abt++; end
         if (tr_em[e] === 1'b0 && f_emlo < 0) f_emlo = e;
         if (tr_mv[e] === 2'b10 && f_mv10 < 0) f_mv10 = e;
         if (tr_mv[e] === 2'b11) c_mv11++;
         if (f_fall >= 0 && tr_busy[e] !== 1'b0) c_busy_after++;
         if (tr_busy[e] === 1'b0 && f_fall < 0) f_fall = e;
      end
      if (f_emlo >= 0)
         for (int e = f_emlo + 1; e < NE; e++)
            if (tr_em[e] === 1'b1 && f_emhi < 0) f_emhi = e;

      n_checks++;
      if ({tr_mv[0], tr_busy[0]} !== 3'b011)
         begin n_errors++; $display("FAIL job%0d_start: got {mv,busy}=%b want 011", mode, {tr_mv[0], tr_busy[0]}); end
      n_checks++;
      if (f_pick != exp_pick || c_pick != (exp_pick >= 0 ? 1 : 0))
         begin n_errors++; $display("FAIL job%0d_pick_done: got edge %0d x%0d want edge %0d (n=%0d a=%0d)", mode, f_pick, c_pick, exp_pick, n, a); end
      n_checks++;
      if (f_drop != exp_drop || c_drop != (exp_drop >= 0 ? 1 : 0))
         begin n_errors++; $display("FAIL job%0d_drop_done: got edge %0d x%0d want edge %0d (d=%0d a=%0d)", mode, f_drop, c_drop, exp_drop, d, a); end
      n_checks++;
      if (f_abt != exp_abt || c_abt != (exp_abt >= 0 ? 1 : 0))
         begin n_errors++; $display("FAIL job%0d_abort_done: got edge %0d x%0d want edge %0d (a=%0d)", mode, f_abt, c_abt, exp_abt, a); end
      n_checks++;
      if (f_emlo != exp_emlo)
         begin n_errors++; $display("FAIL job%0d_em_on: got edge %0d want %0d", mode, f_emlo, exp_emlo); end
      n_checks++;
      if (f_emhi != exp_emhi)
         begin n_errors++; $display("FAIL job%0d_em_off: got edge %0d want %0d", mode, f_emhi, exp_emhi); end
      n_checks++;
      if (f_fall != fall || c_busy_after != 0)
         begin n_errors++; $display("FAIL job%0d_busy_fall: got edge %0d (rebusy %0d) want %0d", mode, f_fall, c_busy_after, fall); end
      n_checks++;
      if (f_mv10 != exp_pick)
         begin n_errors++; $display("FAIL job%0d_move_drop: got edge %0d want %0d", mode, f_mv10, exp_pick); end
      n_checks++;
      if (c_mv11 != 0)
         begin n_errors++; $display("FAIL job%0d_move_11: got %0d cycles want 0", mode, c_mv11); end
   endtask

   task automatic test_async_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      at_pick = 1'b1;
      tick();
      at_pick = 1'b0;
      tick();
      n_checks++;
      if (em_state !== 1'b0) begin n_errors++; $display("FAIL arst_pre_grab: got em %b want 0", em_state); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({em_state, busy, move_req} !== 4'b1000)
         begin n_errors++; $display("FAIL arst_immediate: got {em,busy,mv}=%b want 1000", {em_state, busy, move_req}); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      n_checks++;
      if ({em_state, busy, pick_done} !== 3'b100)
         begin n_errors++; $display("FAIL arst_after: got {em,busy,pick}=%b want 100", {em_state, busy, pick_done}); end
   endtask

`ifdef MOVE_TIMEOUT_EN
   task automatic test_timeout();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (k == TO - 1) begin
            n_checks++;
            if ({timeout_err, abort_done, busy} !== 3'b001)
               begin n_errors++; $display("FAIL tmo_early: got {err,abt,busy}=%b want 001", {timeout_err, abort_done, busy}); end
         end
      end
      n_checks++;
      if ({timeout_err, abort_done, busy, em_state} !== 4'b1101)
         begin n_errors++; $display("FAIL tmo_fire: got {err,abt,busy,em}=%b want 1101", {timeout_err, abort_done, busy, em_state}); end
      tick(); tick(); tick();
      n_checks++;
      if (timeout_err !== 1'b1) begin n_errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({timeout_err, busy} !== 2'b01)
         begin n_errors++; $display("FAIL tmo_clear: got {err,busy}=%b want 01", {timeout_err, busy}); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_start_abort();
      for (int i = 0; i < 25; i++) run_job(i % 5);
      test_async_reset();
`ifdef MOVE_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pick_drop_sequencer.md
Name: pick_drop_sequencer

Overview:
- Mission-level sequencer for the pick-and-place bot. It sits directly upstream of the electromagnet driver and produces that driver's one-bit `state` input (0 = PICK/energise, 1 = DROP/release).
- It requests motion to the pickup and drop nodes and waits for arrival from navigation.
- It holds the magnet through configurable settle and release dwells, and reports completion with single-cycle pulses.

Parameters:
- SETTLE_CYC, 50000, cycles the magnet is held energised at the pickup node before requesting the move to drop (1 ms at 50 MHz); must be ≥1.
- RELEASE_CYC, 25000, cycles held at the drop node after de-energising before reporting done; must be ≥1.
- CNT_W, 20, dwell/timeout counter width; must hold max(SETTLE_CYC, RELEASE_CYC, TIMEOUT_CYC) − 1.
- TIMEOUT_CYC, 1000000, maximum cycles allowed in a move state (used only with MOVE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one pick-drop job; sampled only in IDLE.
- abort  in  1  level; cancel the current job.
- at_pick  in  1  navigation: robot is at the pickup node.
- at_drop  in  1  navigation: robot is at the drop node.
- em_state  out  1  to the electromagnet driver: 0 = PICK, 1 = DROP.
- move_req  out  2  00 = hold, 01 = go to pick, 10 = go to drop; 11 is never driven.
- busy  out  1  high in every state except IDLE.
- pick_done  out  1  one-cycle pulse when the settle dwell completes.
- drop_done  out  1  one-cycle pulse when a normal job completes.
- abort_done  out  1  one-cycle pulse when an aborted job returns to IDLE.
- timeout_err  out  1  sticky move-timeout flag; port exists only when MOVE_TIMEOUT_EN is defined.

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE, em_state = 1 (magnet off), move_req = 00, busy = 0, all pulses 0, counter = 0, timeout_err = 0.
- States: IDLE, GO_PICK, GRAB, GO_DROP, RELEASE.
- IDLE:
  - start && !abort → GO_PICK; move_req = 01, busy = 1.
  - If start and abort are high in the same cycle, stay in IDLE.
- GO_PICK:
  - at_pick → GRAB; em_state = 0, move_req = 00, counter = SETTLE_CYC − 1.
  - Occupies at least one cycle even if at_pick is already high on entry.
- GRAB:
  - Decrement the counter each cycle.
  - When the counter reads 0 → GO_DROP; move_req = 10, pick_done = 1 for that cycle.
  - Dwell is exactly SETTLE_CYC cycles, which covers the driver's one-register latency.
- GO_DROP:
  - at_drop → RELEASE; em_state = 1, move_req = 00, counter = RELEASE_CYC − 1.
- RELEASE:
  - Count down.
  - At 0 → IDLE; busy = 0 and drop_done = 1 in the same cycle, or abort_done = 1 instead if the aborted flag is set. Then clear the aborted flag.
- Abort handling (abort takes priority over every other transition condition):
  - GO_PICK → IDLE immediately; move_req = 00, abort_done = 1. No magnet activity.
  - GRAB or GO_DROP (load possibly held) → RELEASE; em_state = 1, move_req = 00, counter = RELEASE_CYC − 1, set the aborted flag.
  - RELEASE → ignored; the dwell finishes.
- start while busy is ignored; there is no queueing.
- at_pick/at_drop are relevant only in their own state; e.g. at_drop high in GO_PICK has no effect.
- Assertion of rst_n at any point returns all state, outputs and counter to their reset values immediately, dropping the magnet.

Optional Feature:
- MOVE_TIMEOUT_EN defined:
  - A counter runs in GO_PICK and GO_DROP.
  - If the arrival input is not seen within TIMEOUT_CYC cycles, act exactly as abort in that state, and set timeout_err.
  - timeout_err stays high until the next accepted start or reset.
- MOVE_TIMEOUT_EN undefined: no timeout counter, no timeout_err port, and move states wait indefinitely.

Test Plan (SETTLE_CYC = 4, RELEASE_CYC = 3, TIMEOUT_CYC = 10):
- Reset release → em_state = 1, move_req = 00, busy = 0; start pulse → after the next edge move_req = 01, busy = 1.
- Normal job: at_pick high at cycle N → em_state = 0 after edge N, pick_done exactly 4 cycles later with move_req = 10; at_drop → em_state = 1, drop_done 3 cycles later, busy = 0 in the same cycle.
- Abort in GO_DROP → em_state = 1 next cycle, abort_done 3 cycles later, drop_done never asserted; abort in GO_PICK → abort_done next cycle, em_state stays 1.
- start + abort in the same IDLE cycle → remains IDLE; start during GRAB → ignored, job completes normally.
- rst_n low during GRAB → em_state = 1 and state = IDLE asynchronously, without waiting for a clock edge.
- MOVE_TIMEOUT_EN: at_pick never asserted → after 10 cycles in GO_PICK, timeout_err = 1 and abort_done pulses; the next start clears timeout_err.
